// File: rtl/io_tx_sequencer_if.sv
// Bus bundle for io_tx_sequencer: block request, result-memory read port, host transmit port, status.
// Handshake: tx_valid rises together with tx_data and both hold until a clock edge where tx_ack=1,
// which transfers the word; tx_ack while tx_valid=0 has no effect.
interface io_tx_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
);
    logic              start;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ack;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent;

    modport master (
        input  start, count, base_addr, mem_data, tx_ack,
        output mem_rd, mem_addr, tx_data, tx_valid, busy, done, sent
    );

    modport slave (
        output start, count, base_addr, mem_data, tx_ack,
        input  mem_rd, mem_addr, tx_data, tx_valid, busy, done, sent
    );
endinterface

// File: rtl/io_tx_sequencer.sv
// io_tx_sequencer: fetches a block of result-memory words and streams them to the host over valid/ack.
// Optional: define IO_TX_CHECKSUM_EN to append a modulo-2^DATA_W checksum word after the data words.
module io_tx_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    io_tx_sequencer_if.master bus,
    output logic [2:0]        fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
`ifdef IO_TX_CHECKSUM_EN
        , S_CSUM = 3'd5
`endif
    } state_t;

    // State entered once the data words are exhausted (or count was zero).
`ifdef IO_TX_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_inc;
    logic [CNT_W-1:0]  sent_inc;
    logic              last_word;
    logic              accept;
    logic              ack;
`ifdef IO_TX_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;
`endif

    assign addr_inc  = addr_r + ADDR_W'(1);
    assign sent_inc  = bus.sent + CNT_W'(1);
    assign last_word = (sent_inc == cnt_r);
    assign accept    = (state == S_IDLE) && bus.start;
    assign ack       = (state == S_SEND) && bus.tx_ack;
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.count == '0) ? S_TAIL : S_FETCH;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_SEND;
            S_SEND: begin
                if (bus.tx_ack) begin
                    state_next = last_word ? S_TAIL : S_FETCH;
                end
            end
`ifdef IO_TX_CHECKSUM_EN
            S_CSUM: begin
                if (bus.tx_ack) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_r        <= '0;
            addr_r       <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sent     <= '0;
`ifdef IO_TX_CHECKSUM_EN
            csum_r       <= '0;
`endif
        end else begin
            state      <= state_next;
            // The read strobe is high exactly for the FETCH cycle; done lags DONE by one edge,
            // so it rises on the same edge that drops busy.
            bus.mem_rd <= (state_next == S_FETCH);
            bus.done   <= (state == S_DONE);

            if (accept) begin
                cnt_r        <= bus.count;
                addr_r       <= bus.base_addr;
                bus.mem_addr <= bus.base_addr;
                bus.sent     <= '0;
                bus.busy     <= 1'b1;
`ifdef IO_TX_CHECKSUM_EN
                csum_r       <= '0;
                if (bus.count == '0) begin
                    bus.tx_data  <= '0;
                    bus.tx_valid <= 1'b1;
                end
`endif
            end

            if (state == S_WAIT) begin
                bus.tx_data  <= bus.mem_data;
                bus.tx_valid <= 1'b1;
            end

            if (ack) begin
                bus.tx_valid <= 1'b0;
                bus.sent     <= sent_inc;
                addr_r       <= addr_inc;
                bus.mem_addr <= addr_inc;
`ifdef IO_TX_CHECKSUM_EN
                csum_r       <= csum_r + bus.tx_data;
                if (last_word) begin
                    bus.tx_data  <= csum_r + bus.tx_data;
                    bus.tx_valid <= 1'b1;
                end
`endif
            end

`ifdef IO_TX_CHECKSUM_EN
            if ((state == S_CSUM) && bus.tx_ack) begin
                bus.tx_valid <= 1'b0;
            end
`endif

            if (state == S_DONE) begin
                bus.busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_io_tx_sequencer.sv
// Self-checking bench for io_tx_sequencer: block-level transfer model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_io_tx_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fsm_state;

    io_tx_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    io_tx_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result memory: synchronous read, data valid the cycle after mem_rd.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (rst) bus.mem_data <= '0;
        else if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Transfer model: words expected on the host port, in order.
    logic [DATA_W-1:0] exp_q[$];
    bit                valid_exp, in_csum, tail, done_exp, busy_exp;
    int                vcnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  sent_exp, cnt_m;
    logic [DATA_W-1:0] csum_m;

    task automatic finish_data();
`ifdef IO_TX_CHECKSUM_EN
        in_csum   = 1'b1;
        valid_exp = 1'b1;
        exp_q.push_back(csum_m);
`else
        tail = 1'b1;
`endif
    endtask

    always @(posedge clk) begin : model_step
        bit hs;
        bit busy_prev;
        if (rst) begin
            valid_exp = 0; in_csum = 0; tail = 0; done_exp = 0; busy_exp = 0;
            vcnt = 0; rd_addr = '0; sent_exp = '0; cnt_m = '0; csum_m = '0;
            exp_q.delete();
        end else begin
            hs        = valid_exp && bus.tx_ack;
            busy_prev = busy_exp;
            done_exp  = 1'b0;
            if (tail) begin
                tail = 1'b0; done_exp = 1'b1; busy_exp = 1'b0;
            end
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) valid_exp = 1'b1;
            end
            if (hs) begin
                valid_exp = 1'b0;
                if (in_csum) begin
                    in_csum = 1'b0;
                    tail    = 1'b1;
                    void'(exp_q.pop_front());
                end else begin
                    csum_m = csum_m + exp_q[0];
                    void'(exp_q.pop_front());
                    sent_exp++;
                    rd_addr++;
                    if (sent_exp == cnt_m) finish_data();
                    else vcnt = 2;
                end
            end
            if (!busy_prev && bus.start) begin
                busy_exp = 1'b1; sent_exp = '0; cnt_m = bus.count;
                rd_addr = bus.base_addr; csum_m = '0;
                exp_q.delete();
                for (int i = 0; i < int'(bus.count); i++)
                    exp_q.push_back(mem[bus.base_addr + ADDR_W'(i)]);
                if (bus.count == '0) finish_data();
                else vcnt = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid", bus.tx_valid, valid_exp);
            if (valid_exp)
                check("tx_data", bus.tx_data, (exp_q.size() > 0) ? exp_q[0] : {DATA_W{1'bx}});
            check("mem_rd", bus.mem_rd, vcnt == 2);
            if (vcnt == 2) check("mem_addr", bus.mem_addr, rd_addr);
            check("busy", bus.busy, busy_exp);
            check("done", bus.done, done_exp);
            check("sent", bus.sent, sent_exp);
        end
    end

    // Observation logs for the literal checks.
    logic [DATA_W-1:0] got_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    always @(posedge clk) begin
        if (bus.tx_valid && bus.tx_ack) got_q.push_back(bus.tx_data);
        if (bus.mem_rd) addr_q.push_back(bus.mem_addr);
    end

    function automatic logic [DATA_W-1:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : {DATA_W{1'bx}};
    endfunction

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        bus.base_addr = base;
        bus.count     = cnt;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", bus.done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int done_cnt;
        bus.start = 1'b0; bus.count = '0; bus.base_addr = '0; bus.tx_ack = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_sent", bus.sent, 0);
        check("rst_mem_rd", bus.mem_rd, 1'b0);
        check("rst_state", fsm_state, 3'd0);
        rst = 1'b0;
        addr_q.delete();
        repeat (6) @(negedge clk);
        check("idle_no_mem_rd", addr_q.size(), 0);

        // Basic block, ack tied high
        mem[16'h0010] = 32'hA; mem[16'h0011] = 32'hB; mem[16'h0012] = 32'hC;
        bus.tx_ack = 1'b1;
        got_q.delete();
        pulse_start(16'h0010, 3);
        n = 1;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", n, 3);
        wait_done(40, c);
        check("basic_sent", bus.sent, 3);
        check("basic_w0", got_at(0), 32'hA);
        check("basic_w1", got_at(1), 32'hB);
        check("basic_w2", got_at(2), 32'hC);
`ifdef IO_TX_CHECKSUM_EN
        check("basic_csum", got_at(3), 32'h21);
`endif
        @(negedge clk);
        check("basic_busy_after_done", bus.busy, 1'b0);
        repeat (2) @(negedge clk);

        // Backpressure on word 1
        mem[16'h0020] = 32'h1111_1111; mem[16'h0021] = 32'h2222_2222;
        bus.tx_ack = 1'b0;
        got_q.delete();
        pulse_start(16'h0020, 2);
        n = 1;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.tx_valid, 1'b1);
            check("bp_data", bus.tx_data, 32'h1111_1111);
            check("bp_no_rd", bus.mem_rd, 1'b0);
            check("bp_sent", bus.sent, 0);
            @(negedge clk);
        end
        bus.tx_ack = 1'b1;
        wait_done(40, c);
        check("bp_sent_final", bus.sent, 2);
        check("bp_w1", got_at(1), 32'h2222_2222);
        repeat (3) @(negedge clk);

        // Zero-length block
        got_q.delete();
        pulse_start(16'h0123, 0);
        wait_done(20, c);
`ifdef IO_TX_CHECKSUM_EN
        check("zero_done_latency", 1 + c, 3);
        check("zero_words", got_q.size(), 1);
        check("zero_csum", got_at(0), 32'h0);
`else
        check("zero_done_latency", 1 + c, 2);
        check("zero_words", got_q.size(), 0);
`endif
        check("zero_sent", bus.sent, 0);
        repeat (3) @(negedge clk);

        // Start while busy is ignored
        for (int i = 0; i < 4; i++) mem[16'h0030 + i] = 32'hC0DE_0000 + i;
        got_q.delete();
        pulse_start(16'h0030, 4);
        repeat (3) @(negedge clk);
        pulse_start(16'h0040, 9);
        wait_done(60, c);
        check("restart_sent", bus.sent, 4);
        check("restart_w3", got_at(3), 32'hC0DE_0003);
        repeat (4) @(negedge clk);
        check("sent_holds", bus.sent, 4);

        // Address wrap
        mem[16'hFFFF] = 32'h5555_0001; mem[16'h0000] = 32'h5555_0002;
        addr_q.delete();
        got_q.delete();
        pulse_start(16'hFFFF, 2);
        wait_done(40, c);
        check("wrap_reads", addr_q.size(), 2);
        check("wrap_addr0", (addr_q.size() > 0) ? addr_q[0] : 16'hxxxx, 16'hFFFF);
        check("wrap_addr1", (addr_q.size() > 1) ? addr_q[1] : 16'hxxxx, 16'h0000);
        check("wrap_w1", got_at(1), 32'h5555_0002);
        repeat (3) @(negedge clk);

        // Reset mid-block after two acks
        got_q.delete();
        pulse_start(16'h0050, 5);
        n = 0;
        while (got_q.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_two_acks", got_q.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", bus.tx_valid, 1'b0);
        check("mid_rst_sent", bus.sent, 0);
        check("mid_rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);

`ifdef IO_TX_CHECKSUM_EN
        // Checksum wraps modulo 2^DATA_W
        mem[16'h0060] = 32'hFFFF_FFFF; mem[16'h0061] = 32'h0000_0002;
        got_q.delete();
        pulse_start(16'h0060, 2);
        wait_done(40, c);
        check("csum_words", got_q.size(), 3);
        check("csum_value", got_at(2), 32'h0000_0001);
        check("csum_sent", bus.sent, 2);
        repeat (3) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
